wb_block_loader: RTL and testbench
==================================

// Module: wb_block_loader
// PURPOSE
// - Wishbone B4 classic initiator that copies LEN 32-bit words from a source address to a destination address, one read then one write per word.
// - Feeds message blocks into the SHA3 peripheral data window (0x3000_0020..) without CPU word-by-word stores; destination is any Wishbone responder.
// - Control is a start/busy/done/err side interface driven by a CSR block. Bus errors and timeouts are reported through err.
// PARAMETERS
// - LEN_W      8    width of len; max transfer 2^LEN_W-1 words
// - TIMEOUT    255  cycles to wait for ack/err per access before aborting (>=1)
// - TMO_W      8    width of timeout counter; must hold TIMEOUT
// PORTS
// - wb_clk_i    in   1      Wishbone clock; single clock domain
// - wb_rst_ni   in   1      asynchronous active-low reset
// - start_i     in   1      1-cycle pulse; launches transfer when idle
// - src_addr_i  in   32     first read address, word-aligned, sampled at start
// - dst_addr_i  in   32     first write address, word-aligned, sampled at start
// - len_i       in   LEN_W  word count, sampled at start
// - busy_o      out  1      high from cycle after accepted start until done/err
// - done_o      out  1      1-cycle pulse: all words written
// - err_o       out  1      sticky abort flag; cleared by next accepted start
// - wbm_cyc_o   out  1      bus cycle
// - wbm_stb_o   out  1      strobe
// - wbm_we_o    out  1      1=write, 0=read
// - wbm_adr_o   out  32     byte address
// - wbm_dat_o   out  32     write data (last read word)
// - wbm_sel_o   out  4      byte selects, always 4'hF while stb
// - wbm_dat_i   in   32     read data
// - wbm_ack_i   in   1      responder ack
// - wbm_err_i   in   1      responder error
// BEHAVIOUR
// - Reset (async, wb_rst_ni=0): state IDLE, all outputs 0, address/count/timeout regs 0. Reset mid-transfer drops cyc/stb immediately; no completion reported.
// - FSM: IDLE -> RD (start_i & len_i!=0) -> WR on ack_i -> RD on ack_i if words remain, else DONE -> IDLE.
// - IDLE with start_i & len_i==0: pulse done_o next cycle, no bus traffic, err_o cleared.
// - start_i while busy_o: ignored; sampled inputs unchanged.
// - RD: cyc=stb=1, we=0, adr=src ptr. On ack_i, latch wbm_dat_i into data reg, drop stb for exactly one cycle (responder ack is registered and re-asserts if stb held), then enter WR.
// - WR: cyc=stb=1, we=1, adr=dst ptr, dat_o=data reg. On ack_i, src/dst ptrs +4, count -1, one idle stb cycle before next RD.
// - Pointer increment is modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000); no error.
// - cyc_o stays high only while stb_o high; dropped with stb in the gap cycles.
// - Outputs held stable while stb=1 and no ack/err (classic handshake).
// - Per-access timeout counter: reset to 0 on every new stb assertion, +1 each waiting cycle; reaching TIMEOUT with no ack -> abort.
// - Abort (wbm_err_i or timeout): drop cyc/stb next cycle, set err_o, busy_o=0, no done_o, -> IDLE.
// - ack_i and err_i same cycle: err wins.
// - ack_i/err_i while stb=0: ignored.
// - Latency per word with zero-wait responder: 2 cycles/access + 1 gap = 6 cycles/word; done_o 1 cycle after final write ack.
// STRUCTURE
// - Shared package wb_pkg: state encoding localparams (IDLE, RD, RD_GAP, WR, WR_GAP, DONE), WB_WORD_BYTES=4, WB_SEL_ALL=4'hF.
// - One sub-module: wb_access_timer (TMO_W counter, clear/enable in, expired out), reusable by later initiators.
// - Datapath regs (src ptr, dst ptr, count, data) in top; FSM single always block with async reset.
// TESTING
// - len=3, src=0x1000_0000 (mem 0xA1,0xB2,0xC3), dst=0x3000_0020, zero-wait slave -> writes 0xA1@0x20,0xB2@0x24,0xC3@0x28 in order; done_o pulse once.
// - len=0 start -> done_o 1 cycle later, cyc_o never asserted, busy_o stays 0.
// - Slave acks read, asserts err_i on 2nd write (len=4) -> err_o=1 sticky, no done_o, exactly 2 writes seen; next start clears err_o.
// - Silent slave, TIMEOUT=15 -> stb held 15 cycles, then cyc/stb drop, err_o=1, busy_o=0.
// - src=0xFFFF_FFF8, len=3 -> reads at 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; transfer completes without error.
// - Assert wb_rst_ni=0 during 2nd word's read wait -> cyc/stb/busy 0 same cycle; restart with len=2 completes correctly; start_i pulsed mid-transfer ignored.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone initiator definitions: FSM state encoding, bus constants, request payload.
package wb_pkg;

    localparam int unsigned WB_ADR_W      = 32;
    localparam int unsigned WB_DAT_W      = 32;
    localparam int unsigned WB_SEL_W      = 4;
    localparam int unsigned WB_WORD_BYTES = 4;

    localparam logic [WB_SEL_W-1:0] WB_SEL_ALL = 4'hF;

    // Initiator sequencing states; the *_GAP states hold stb low for one cycle
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RD_GAP = 3'd2,
        WR     = 3'd3,
        WR_GAP = 3'd4,
        DONE   = 3'd5
    } wb_state_e;

    // Initiator-driven Wishbone signals, registered as one payload
    typedef struct packed {
        logic                cyc;
        logic                stb;
        logic                we;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
    } wb_req_t;

endpackage

// File: rtl/wb_access_timer.sv
// Per-access watchdog: counts waiting cycles of one bus access and flags expiry.
module wb_access_timer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TMO_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired_c
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] cnt_q;

    // Waiting-cycle counter, restarted whenever the access is not in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + TMO_W'(1);
        end
    end

    // Expiry fires on the waiting cycle that would bring the count to TIMEOUT
    assign expired_c = en & (cnt_q == LAST);

endmodule

// File: rtl/wb_block_loader.sv
// Wishbone classic initiator copying len 32-bit words from src to dst, one read then one write per word.
module wb_block_loader
    import wb_pkg::*;
#(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TMO_W   = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                start_i,
    input  logic [WB_ADR_W-1:0] src_addr_i,
    input  logic [WB_ADR_W-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]    len_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    input  logic [WB_DAT_W-1:0] wbm_dat_i,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i
);

    wb_state_e           state_q, state_d;
    logic [WB_ADR_W-1:0] src_q, src_d;
    logic [WB_ADR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [WB_DAT_W-1:0] data_q, data_d;
    wb_req_t             req_q, req_d;
    logic                busy_d, done_d, err_d;
    logic                tmo_expired_c;
    logic                acc_ack_c, acc_abort_c;

    // Handshake qualification: responses only count while strobing, error beats ack
    assign acc_abort_c = wbm_stb_o & (wbm_err_i | tmo_expired_c);
    assign acc_ack_c   = wbm_stb_o & wbm_ack_i & ~wbm_err_i;

    wb_access_timer #(
        .TIMEOUT (TIMEOUT),
        .TMO_W   (TMO_W)
    ) u_timer (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .clear     (~wbm_stb_o),
        .en        (wbm_stb_o & ~wbm_ack_i & ~wbm_err_i),
        .expired_c (tmo_expired_c)
    );

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath updates and next values of all registered outputs
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_o;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_d   = src_addr_i;
                    dst_d   = dst_addr_i;
                    cnt_d   = len_i;
                    err_d   = 1'b0;
                    state_d = (len_i == '0) ? DONE : RD;
                end
            end
            RD: begin
                if (acc_abort_c) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (acc_ack_c) begin
                    data_d  = wbm_dat_i;
                    state_d = RD_GAP;
                end
            end
            RD_GAP: state_d = WR;
            WR: begin
                if (acc_abort_c) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (acc_ack_c) begin
                    src_d   = src_q + WB_ADR_W'(WB_WORD_BYTES);
                    dst_d   = dst_q + WB_ADR_W'(WB_WORD_BYTES);
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = (cnt_q == LEN_W'(1)) ? DONE : WR_GAP;
                end
            end
            WR_GAP:  state_d = RD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_d     = '0;
        req_d.dat = data_d;
        if ((state_d == RD) || (state_d == WR)) begin
            req_d.cyc = 1'b1;
            req_d.stb = 1'b1;
            req_d.we  = (state_d == WR);
            req_d.adr = (state_d == WR) ? dst_d : src_d;
            req_d.sel = WB_SEL_ALL;
        end

        busy_d = (state_d inside {RD, RD_GAP, WR, WR_GAP});
        done_d = (state_d == DONE);
    end

    // Datapath and output registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            src_q  <= '0;
            dst_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            req_q  <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            req_q  <= req_d;
            busy_o <= busy_d;
            done_o <= done_d;
            err_o  <= err_d;
        end
    end

    assign wbm_cyc_o = req_q.cyc;
    assign wbm_stb_o = req_q.stb;
    assign wbm_we_o  = req_q.we;
    assign wbm_adr_o = req_q.adr;
    assign wbm_dat_o = req_q.dat;
    assign wbm_sel_o = req_q.sel;

endmodule

// File: tb/tb_wb_block_loader.sv
// Directed bench for wb_block_loader with a registered-ack Wishbone responder model.
module tb_wb_block_loader;

    localparam int M_NORMAL = 0;
    localparam int M_ERR2   = 1;
    localparam int M_SILENT = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] src;
    logic [31:0] dst;
    logic [7:0]  len;
    logic        busy, done, err;
    logic        cyc, stb, we;
    logic [31:0] adr, wdat, rdat;
    logic [3:0]  sel;
    logic        ack, berr;

    int checks = 0;
    int errors = 0;

    int mode     = M_NORMAL;
    int err_base = 0;

    int          cyc_n      = 0;
    int          done_n     = 0;
    int          done_cyc   = 0;
    int          cyc_seen_n = 0;
    int          inv_bad    = 0;
    int          run        = 0;
    logic [31:0] wadr_q[$];
    logic [31:0] wdat_q[$];
    int          wcyc_q[$];
    logic [31:0] radr_q[$];
    int          runs_q[$];

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [7:0]  len;
        int          mode;
        int          nrd;
        int          nwr;
        logic        err;
        int          ndone;
        int          run;
        logic        cyc;
        logic [31:0] wadr;
        logic [31:0] wdat;
        logic [31:0] radr;
    } vec_t;

    vec_t vecs[7];

    wb_block_loader #(
        .LEN_W   (8),
        .TIMEOUT (15),
        .TMO_W   (8)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .start_i    (start),
        .src_addr_i (src),
        .dst_addr_i (dst),
        .len_i      (len),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (wdat),
        .wbm_sel_o  (sel),
        .wbm_dat_i  (rdat),
        .wbm_ack_i  (ack),
        .wbm_err_i  (berr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        case (a)
            32'h1000_0000: rd_word = 32'h0000_00A1;
            32'h1000_0004: rd_word = 32'h0000_00B2;
            32'h1000_0008: rd_word = 32'h0000_00C3;
            default:       rd_word = a ^ 32'hDEAD_0000;
        endcase
    endfunction

    // Responder: registered ack/err one cycle after seeing a fresh strobe
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack  <= 1'b0;
            berr <= 1'b0;
            rdat <= 32'h0;
        end else begin
            ack  <= 1'b0;
            berr <= 1'b0;
            if (cyc && stb && !ack && !berr) begin
                if (!we) rdat <= rd_word(adr);
                if (mode == M_NORMAL) begin
                    ack <= 1'b1;
                end else if (mode == M_ERR2) begin
                    if (we && (wadr_q.size() - err_base == 1)) berr <= 1'b1;
                    else ack <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Bus monitor sampled mid-cycle
    always @(negedge clk) begin
        if (cyc !== stb) inv_bad++;
        if (stb && (ack || berr)) begin
            if (we) begin
                wadr_q.push_back(adr);
                wdat_q.push_back(wdat);
                wcyc_q.push_back(cyc_n);
            end else if (ack) begin
                radr_q.push_back(adr);
            end
        end
        if (done) begin
            done_n++;
            done_cyc = cyc_n;
        end
        if (cyc) cyc_seen_n++;
        if (stb) run++;
        else if (run != 0) begin
            runs_q.push_back(run);
            run = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [7:0] l);
        @(negedge clk);
        src   = s;
        dst   = d;
        len   = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int bound);
        int n;
        n = 0;
        while (!(done || err) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("end_reached", 32'(done | err), 32'h1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int          wb, rb, db, cb, runb, mx, n;
        logic [31:0] ea[3];
        logic [31:0] ed[3];

        vecs[0] = '{32'h1000_0000, 32'h3000_0020, 8'd3, M_NORMAL, 3, 3, 1'b0, 1, 2,  1'b1,
                    32'h3000_0028, 32'h0000_00C3, 32'h1000_0008};
        vecs[1] = '{32'h1000_0000, 32'h3000_0020, 8'd0, M_NORMAL, 0, 0, 1'b0, 1, 0,  1'b0,
                    32'h0, 32'h0, 32'h0};
        vecs[2] = '{32'h2000_0000, 32'h3000_0020, 8'd4, M_ERR2,   2, 2, 1'b1, 0, 2,  1'b1,
                    32'h3000_0024, 32'hFEAD_0004, 32'h2000_0004};
        vecs[3] = '{32'h1000_0004, 32'h4000_0000, 8'd1, M_NORMAL, 1, 1, 1'b0, 1, 2,  1'b1,
                    32'h4000_0000, 32'h0000_00B2, 32'h1000_0004};
        vecs[4] = '{32'hFFFF_FFF8, 32'h3000_0020, 8'd3, M_NORMAL, 3, 3, 1'b0, 1, 2,  1'b1,
                    32'h3000_0028, 32'hDEAD_0000, 32'h0000_0000};
        vecs[5] = '{32'h1000_0000, 32'h3000_0020, 8'd2, M_SILENT, 0, 0, 1'b1, 0, 15, 1'b1,
                    32'h0, 32'h0, 32'h0};
        vecs[6] = '{32'h1000_0008, 32'h3000_0030, 8'd1, M_NORMAL, 1, 1, 1'b0, 1, 2,  1'b1,
                    32'h3000_0030, 32'h0000_00C3, 32'h1000_0008};

        ea[0] = 32'h3000_0020; ea[1] = 32'h3000_0024; ea[2] = 32'h3000_0028;
        ed[0] = 32'h0000_00A1; ed[1] = 32'h0000_00B2; ed[2] = 32'h0000_00C3;

        rst_n = 1'b0;
        start = 1'b0;
        src   = 32'h0;
        dst   = 32'h0;
        len   = 8'd0;

        // Reset state
        @(negedge clk);
        chk("rst_cyc",  32'(cyc),  32'h0);
        chk("rst_stb",  32'(stb),  32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err",  32'(err),  32'h0);
        chk("rst_adr",  adr,       32'h0);
        chk("rst_sel",  32'(sel),  32'h0);
        chk("rst_dat",  wdat,      32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_stb", 32'(stb), 32'h0);

        // Three-word copy into the SHA3 window: first access and full write order
        mode = M_NORMAL;
        wb = wadr_q.size();
        db = done_n;
        pulse_start(32'h1000_0000, 32'h3000_0020, 8'd3);
        chk("first_busy", 32'(busy), 32'h1);
        chk("first_stb",  32'(stb),  32'h1);
        chk("first_we",   32'(we),   32'h0);
        chk("first_adr",  adr,       32'h1000_0000);
        chk("first_sel",  32'(sel),  32'hF);
        wait_end(300);
        chk("seq_nwr", 32'(wadr_q.size() - wb), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (wadr_q.size() > wb + k) begin
                chk($sformatf("seq_wadr%0d", k), wadr_q[wb + k], ea[k]);
                chk($sformatf("seq_wdat%0d", k), wdat_q[wb + k], ed[k]);
            end
        end
        chk("seq_done_cnt", 32'(done_n - db), 32'd1);
        chk("seq_busy_end", 32'(busy), 32'h0);

        // Zero-length start: done pulse next cycle, no bus activity
        cb = cyc_seen_n;
        pulse_start(32'h1000_0000, 32'h3000_0020, 8'd0);
        chk("len0_done", 32'(done), 32'h1);
        chk("len0_busy", 32'(busy), 32'h0);
        @(negedge clk);
        chk("len0_done_pulse", 32'(done), 32'h0);
        chk("len0_no_cyc", 32'(cyc_seen_n - cb), 32'd0);

        // Table of whole transfers
        for (int i = 0; i < 7; i++) begin
            mode     = vecs[i].mode;
            wb       = wadr_q.size();
            rb       = radr_q.size();
            db       = done_n;
            cb       = cyc_seen_n;
            runb     = runs_q.size();
            err_base = wb;
            pulse_start(vecs[i].src, vecs[i].dst, vecs[i].len);
            chk($sformatf("v%0d_err_clr", i), 32'(err), 32'h0);
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].len != 8'd0));
            wait_end(400);
            chk($sformatf("v%0d_nrd", i), 32'(radr_q.size() - rb), 32'(vecs[i].nrd));
            chk($sformatf("v%0d_nwr", i), 32'(wadr_q.size() - wb), 32'(vecs[i].nwr));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
            chk($sformatf("v%0d_ndone", i), 32'(done_n - db), 32'(vecs[i].ndone));
            chk($sformatf("v%0d_busy_end", i), 32'(busy), 32'h0);
            chk($sformatf("v%0d_cyc_seen", i), 32'(cyc_seen_n != cb), 32'(vecs[i].cyc));
            mx = 0;
            for (int k = runb; k < runs_q.size(); k++) if (runs_q[k] > mx) mx = runs_q[k];
            chk($sformatf("v%0d_stb_run", i), 32'(mx), 32'(vecs[i].run));
            if (vecs[i].nwr > 0 && wadr_q.size() > wb) begin
                chk($sformatf("v%0d_last_wadr", i), wadr_q[wadr_q.size() - 1], vecs[i].wadr);
                chk($sformatf("v%0d_last_wdat", i), wdat_q[wdat_q.size() - 1], vecs[i].wdat);
            end
            if (vecs[i].nrd > 0 && radr_q.size() > rb)
                chk($sformatf("v%0d_last_radr", i), radr_q[radr_q.size() - 1], vecs[i].radr);
            if (vecs[i].ndone == 1 && vecs[i].nwr > 0 && wcyc_q.size() > wb)
                chk($sformatf("v%0d_done_lat", i), 32'(done_cyc - wcyc_q[wcyc_q.size() - 1]), 32'd1);
            if (vecs[i].ndone == 1 && vecs[i].nwr >= 2 && wcyc_q.size() >= wb + 2)
                chk($sformatf("v%0d_word_gap", i),
                    32'(wcyc_q[wcyc_q.size() - 1] - wcyc_q[wcyc_q.size() - 2]), 32'd6);
        end

        // Reset during the second word's read wait
        mode = M_NORMAL;
        rb = radr_q.size();
        pulse_start(32'h1000_0000, 32'h3000_0020, 8'd3);
        n = 0;
        while (!(stb && !we && (radr_q.size() - rb == 1)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_rst_reached", 32'(stb && !we), 32'h1);
        db = done_n;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc",  32'(cyc),  32'h0);
        chk("mid_rst_stb",  32'(stb),  32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_no_done", 32'(done_n - db), 32'd0);
        chk("mid_rst_err", 32'(err), 32'h0);

        // Restart with a start pulse injected mid-transfer that must be ignored
        wb = wadr_q.size();
        db = done_n;
        pulse_start(32'h1000_0000, 32'h5000_0000, 8'd2);
        chk("restart_busy", 32'(busy), 32'h1);
        repeat (4) @(negedge clk);
        pulse_start(32'h0000_0000, 32'h6000_0000, 8'd5);
        wait_end(300);
        chk("restart_nwr", 32'(wadr_q.size() - wb), 32'd2);
        if (wadr_q.size() >= wb + 2) begin
            chk("restart_wadr0", wadr_q[wb],     32'h5000_0000);
            chk("restart_wdat0", wdat_q[wb],     32'h0000_00A1);
            chk("restart_wadr1", wadr_q[wb + 1], 32'h5000_0004);
            chk("restart_wdat1", wdat_q[wb + 1], 32'h0000_00B2);
        end
        chk("restart_done", 32'(done_n - db), 32'd1);
        chk("restart_err", 32'(err), 32'h0);

        chk("cyc_follows_stb", 32'(inv_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
